// File: rtl/alu_mult_sequencer_if.sv
// Handshake and operand bundle between the calculator control FSM
// and the sequential 8x8 sign-magnitude multiplier.
interface alu_mult_sequencer_if;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        sign_A;
    logic        sign_B;
    logic        busy;
    logic        done;
    logic [15:0] P;
    logic        Final_sign;

    modport master (
        output start, A, B, sign_A, sign_B,
        input  busy, done, P, Final_sign
    );

    modport slave (
        input  start, A, B, sign_A, sign_B,
        output busy, done, P, Final_sign
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Sequential 8x8 sign-magnitude multiplier: one shared 4x4 multiplier, four nibble steps.
// Optional macro ALU_MULT_ZERO_SKIP_EN: zero operands go straight to DONE with P=0.
module alu_mult_sequencer #(
    parameter int unsigned CLR_ON_START = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_mult_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;
    logic        sign_q, sign_d;

    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  prod;
    logic [15:0] shifted;
    logic [15:0] acc_sum;
    logic        accept;
    logic        busy_o;
    logic        done_o;

`ifdef ALU_MULT_ZERO_SKIP_EN
    logic        zero_op;
    assign zero_op = (bus.A == 8'd0) || (bus.B == 8'd0);
`endif

    assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));

    // Pick the nibble pair for the current step from the captured operands.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        unique case (state_q)
            MUL0: begin
                nib_a = a_q[3:0];
                nib_b = b_q[3:0];
            end
            MUL1: begin
                nib_a = a_q[7:4];
                nib_b = b_q[3:0];
            end
            MUL2: begin
                nib_a = a_q[3:0];
                nib_b = b_q[7:4];
            end
            MUL3: begin
                nib_a = a_q[7:4];
                nib_b = b_q[7:4];
            end
            default: ;
        endcase
    end

    _4x4_mult u_mult (
        .a (nib_a),
        .b (nib_b),
        .p (prod)
    );

    // Align the partial product to its nibble weight.
    always_comb begin
        shifted = 16'd0;
        unique case (state_q)
            MUL0:       shifted = {8'd0, prod};
            MUL1, MUL2: shifted = {4'd0, prod, 4'd0};
            MUL3:       shifted = {prod, 8'd0};
            default:    ;
        endcase
    end

    // Max total is 0xFE01, so a 16-bit sum never carries out.
    assign acc_sum = acc_q + shifted;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk the four steps, accept start only when idle or done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = MUL0;
`ifdef ALU_MULT_ZERO_SKIP_EN
                    if (zero_op) begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            MUL0:    state_d = MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = MUL3;
            MUL3:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            MUL0, MUL1, MUL2, MUL3: busy_o = 1'b1;
            DONE:                   done_o = 1'b1;
            default:                ;
        endcase
    end

    // Capture operands on accept, accumulate per step, publish on leaving MUL3.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        acc_d  = acc_q;
        p_d    = p_q;
        sign_d = sign_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d   = bus.A;
                    b_d   = bus.B;
                    sa_d  = bus.sign_A;
                    sb_d  = bus.sign_B;
                    acc_d = 16'd0;
                    if (CLR_ON_START != 0) begin
                        p_d    = 16'd0;
                        sign_d = 1'b0;
                    end
`ifdef ALU_MULT_ZERO_SKIP_EN
                    if (zero_op) begin
                        p_d    = 16'd0;
                        sign_d = 1'b0;
                    end
`endif
                end
            end
            MUL0, MUL1, MUL2: begin
                acc_d = acc_sum;
            end
            MUL3: begin
                acc_d  = acc_sum;
                p_d    = acc_sum;
                sign_d = (sa_q ^ sb_q) & (acc_sum != 16'd0);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            acc_q  <= 16'd0;
            p_q    <= 16'd0;
            sign_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            acc_q  <= acc_d;
            p_q    <= p_d;
            sign_q <= sign_d;
        end
    end

    assign bus.busy       = busy_o;
    assign bus.done       = done_o;
    assign bus.P          = p_q;
    assign bus.Final_sign = sign_q;

endmodule

// Shared 4x4 unsigned multiplier used once per step.
module _4x4_mult (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'd0, a} * {4'd0, b};
endmodule
